micro_sequencer: RTL and testbench

- Microprogrammed control unit that drives the ALU/register-bank datapath: ALU opcode, register-bank A/B/C selects, shifter select, Y/KMx mux select, carry-in, and write strobes.
- Consumes the datapath carry-out for conditional branching.
- Fetches microwords from an external synchronous microcode ROM.
- Fixed 4-cycle microinstruction (FETCH, LOAD, LATCH, WRITE) with a START/DONE handshake toward the host controller.

---
 rtl/micro_seq_pkg.sv | 38 +++
 rtl/micro_stack.sv | 49 ++++
 rtl/micro_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_micro_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/micro_seq_pkg.sv
// Shared definitions for the micro_sequencer: microword field positions,
// next-address opcodes and the sequencer state encoding.
package micro_seq_pkg;

  localparam int UADDR_W = 8;
  localparam int UWORD_W = 40;

  localparam int F_ALUC_LSB  = 0;
  localparam int F_SELA_LSB  = 4;
  localparam int F_SELB_LSB  = 10;
  localparam int F_CSEL_LSB  = 16;
  localparam int F_SHIFT_LSB = 22;
  localparam int F_YSEL      = 24;
  localparam int F_WR_RB     = 25;
  localparam int F_WR_RAM    = 26;
  localparam int F_CY_USE    = 27;
  localparam int F_NXT_LSB   = 28;
  localparam int F_TGT_LSB   = 31;
  localparam int F_CY_UPD    = 39;

  localparam logic [2:0] NXT_SEQ  = 3'd0;
  localparam logic [2:0] NXT_JMP  = 3'd1;
  localparam logic [2:0] NXT_JC   = 3'd2;
  localparam logic [2:0] NXT_JNC  = 3'd3;
  localparam logic [2:0] NXT_CALL = 3'd4;
  localparam logic [2:0] NXT_RET  = 3'd5;
  localparam logic [2:0] NXT_HALT = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_LATCH,
    ST_WRITE,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/micro_stack.sv
// Return-address LIFO for CALL/RET. Pushes when full and pops when empty are
// ignored; the sequencer turns those cases into a stack fault.
module micro_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);
  import micro_seq_pkg::*;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW:0]   r_sp;
  logic [AW-1:0] w_top;

  assign o_full  = (r_sp == (AW+1)'(DEPTH));
  assign o_empty = (r_sp == '0);
  assign w_top   = r_sp[AW-1:0] - 1'b1;
  assign o_dout  = r_mem[w_top];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sp <= '0;
    end else if (i_clr) begin
      r_sp <= '0;
    end else if (i_push && !o_full) begin
      r_sp <= r_sp + 1'b1;
    end else if (i_pop && !o_empty) begin
      r_sp <= r_sp - 1'b1;
    end
  end

  // Storage carries no reset; only entries below the pointer are ever read.
  always_ff @(posedge i_clk) begin
    if (i_push && !o_full && !i_clr) begin
      r_mem[r_sp[AW-1:0]] <= i_din;
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogrammed control unit: fixed FETCH/LOAD/LATCH/WRITE cycle per microword.
// Optional single-step HOLD state enabled by defining MICRO_SEQ_SINGLE_STEP_EN.
module micro_sequencer #(
  parameter int STACK_DEPTH = 4,
  parameter int UADDR_W     = 8
) (
  input  logic                               CLK,
  input  logic                               RST_N,
`ifdef MICRO_SEQ_SINGLE_STEP_EN
  input  logic                               STEP_MODE,
  input  logic                               STEP,
`endif
  input  logic                               START,
  input  logic [UADDR_W-1:0]                 ENTRY,
  output logic [UADDR_W-1:0]                 UADDR,
  input  logic [micro_seq_pkg::UWORD_W-1:0]  UWORD,
  input  logic                               CY_OUT,
  output logic [3:0]                         ALUC_IN,
  output logic [5:0]                         SEL_A_RB,
  output logic [5:0]                         SEL_B_RB,
  output logic [5:0]                         C_SEL_RB,
  output logic [1:0]                         Shifter_Sel,
  output logic                               Y_X_Kmx_Sel,
  output logic                               CY_IN,
  output logic                               LATCH_EN,
  output logic                               REGBANK_WE,
  output logic                               RAM_WE,
  output logic                               BUSY,
  output logic                               DONE,
  output logic                               ERR
);
  import micro_seq_pkg::*;

  state_t             r_state, w_state_nxt;
  logic [UWORD_W-1:0] r_ir;
  logic [UADDR_W-1:0] r_upc, w_upc_inc, w_upc_nxt, w_tgt, w_stk_dout;
  logic               r_flag, r_done, r_err;
  logic [2:0]         w_op;
  logic               w_flag_upd, w_push, w_pop, w_halt, w_fault;
  logic               w_full, w_empty, w_start_ok, w_is_write;

  assign w_start_ok = (r_state == ST_IDLE) && START;
  assign w_is_write = (r_state == ST_WRITE);
  assign w_op       = r_ir[F_NXT_LSB +: 3];
  assign w_tgt      = r_ir[F_TGT_LSB +: UADDR_W];
  assign w_upc_inc  = r_upc + 1'b1;
  // Branches see the carry this same WRITE cycle is about to store.
  assign w_flag_upd = r_ir[F_CY_UPD] ? CY_OUT : r_flag;

  always_comb begin
    w_upc_nxt = w_upc_inc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_halt    = 1'b0;
    w_fault   = 1'b0;
    case (w_op)
      NXT_JMP:  w_upc_nxt = w_tgt;
      NXT_JC:   if (w_flag_upd)  w_upc_nxt = w_tgt;
      NXT_JNC:  if (!w_flag_upd) w_upc_nxt = w_tgt;
      NXT_CALL: begin
        if (w_full) begin
          w_fault = 1'b1;
        end else begin
          w_push    = 1'b1;
          w_upc_nxt = w_tgt;
        end
      end
      NXT_RET: begin
        if (w_empty) begin
          w_fault = 1'b1;
        end else begin
          w_pop     = 1'b1;
          w_upc_nxt = w_stk_dout;
        end
      end
      NXT_HALT: w_halt = 1'b1;
      default:  ;
    endcase
  end

  micro_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (UADDR_W)
  ) u_stack (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_clr   (w_start_ok),
    .i_push  (w_is_write & w_push),
    .i_pop   (w_is_write & w_pop),
    .i_din   (w_upc_inc),
    .o_dout  (w_stk_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (START) w_state_nxt = ST_FETCH;
      ST_FETCH: w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_LATCH;
      ST_LATCH: w_state_nxt = ST_WRITE;
      ST_WRITE: begin
        if (w_halt || w_fault) begin
          w_state_nxt = ST_IDLE;
        end else begin
`ifdef MICRO_SEQ_SINGLE_STEP_EN
          // A STEP arriving while HOLD is being entered skips the wait.
          w_state_nxt = (STEP_MODE && !STEP) ? ST_HOLD : ST_FETCH;
`else
          w_state_nxt = ST_FETCH;
`endif
        end
      end
`ifdef MICRO_SEQ_SINGLE_STEP_EN
      ST_HOLD:  if (STEP) w_state_nxt = ST_FETCH;
`endif
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    LATCH_EN   = 1'b0;
    REGBANK_WE = 1'b0;
    RAM_WE     = 1'b0;
    BUSY       = (r_state != ST_IDLE);
    case (r_state)
      ST_LATCH: LATCH_EN = 1'b1;
      ST_WRITE: begin
        REGBANK_WE = r_ir[F_WR_RB];
        RAM_WE     = r_ir[F_WR_RAM];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_upc  <= '0;
      r_ir   <= '0;
      r_flag <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start_ok) begin
        r_upc <= ENTRY;
        r_err <= 1'b0;
      end
      if (r_state == ST_LOAD) begin
        r_ir <= UWORD;
      end
      if (w_is_write) begin
        r_flag <= w_flag_upd;
        if (w_fault) begin
          r_err  <= 1'b1;
          r_done <= 1'b1;
        end else if (w_halt) begin
          r_done <= 1'b1;
        end else begin
          r_upc <= w_upc_nxt;
        end
      end
    end
  end

  assign UADDR       = r_upc;
  assign DONE        = r_done;
  assign ERR         = r_err;
  assign ALUC_IN     = r_ir[F_ALUC_LSB  +: 4];
  assign SEL_A_RB    = r_ir[F_SELA_LSB  +: 6];
  assign SEL_B_RB    = r_ir[F_SELB_LSB  +: 6];
  assign C_SEL_RB    = r_ir[F_CSEL_LSB  +: 6];
  assign Shifter_Sel = r_ir[F_SHIFT_LSB +: 2];
  assign Y_X_Kmx_Sel = r_ir[F_YSEL];
  assign CY_IN       = r_ir[F_CY_USE] & r_flag;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer with a synchronous microcode ROM model.
module tb_micro_sequencer;

  localparam logic [2:0] T_SEQ  = 3'd0;
  localparam logic [2:0] T_JC   = 3'd2;
  localparam logic [2:0] T_JNC  = 3'd3;
  localparam logic [2:0] T_CALL = 3'd4;
  localparam logic [2:0] T_RET  = 3'd5;
  localparam logic [2:0] T_HALT = 3'd6;

  logic        CLK, RST_N, START, CY_OUT;
  logic [7:0]  ENTRY, UADDR;
  logic [39:0] UWORD;
  logic [3:0]  ALUC_IN;
  logic [5:0]  SEL_A_RB, SEL_B_RB, C_SEL_RB;
  logic [1:0]  Shifter_Sel;
  logic        Y_X_Kmx_Sel, CY_IN, LATCH_EN, REGBANK_WE, RAM_WE, BUSY, DONE, ERR;

  logic [39:0] rom [256];
  logic [39:0] fw;
  int n_chk = 0;
  int n_fail = 0;

  micro_sequencer #(.STACK_DEPTH(4), .UADDR_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ENTRY(ENTRY), .UADDR(UADDR),
    .UWORD(UWORD), .CY_OUT(CY_OUT), .ALUC_IN(ALUC_IN), .SEL_A_RB(SEL_A_RB),
    .SEL_B_RB(SEL_B_RB), .C_SEL_RB(C_SEL_RB), .Shifter_Sel(Shifter_Sel),
    .Y_X_Kmx_Sel(Y_X_Kmx_Sel), .CY_IN(CY_IN), .LATCH_EN(LATCH_EN),
    .REGBANK_WE(REGBANK_WE), .RAM_WE(RAM_WE), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) UWORD <= rom[UADDR];

  function automatic logic [39:0] mw(input logic [2:0] nxt, input logic [7:0] tgt,
                                     input logic wr_rb, input logic wr_ram,
                                     input logic cy_use, input logic cy_upd);
    logic [39:0] w;
    w = '0;
    w[30:28] = nxt;
    w[38:31] = tgt;
    w[25] = wr_rb;
    w[26] = wr_ram;
    w[27] = cy_use;
    w[39] = cy_upd;
    return w;
  endfunction

  task automatic clear_rom;
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  task automatic do_reset;
    RST_N = 1'b0;
    START = 1'b0;
    CY_OUT = 1'b0;
    ENTRY = '0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  // Pulses START for one cycle; returns at the negedge of cycle 1 (FETCH).
  task automatic kick(input logic [7:0] e);
    @(negedge CLK);
    START = 1'b1;
    ENTRY = e;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic test_reset;
    logic [57:0] got;
    RST_N = 1'b0; START = 1'b0; CY_OUT = 1'b0; ENTRY = '0;
    clear_rom();
    repeat (2) @(negedge CLK);
    got = {UADDR, ALUC_IN, SEL_A_RB, SEL_B_RB, C_SEL_RB, Shifter_Sel, Y_X_Kmx_Sel,
           CY_IN, LATCH_EN, REGBANK_WE, RAM_WE, BUSY, DONE, ERR, 13'd0};
    n_chk++;
    if (got !== '0) begin
      $display("FAIL reset_outputs: got %h expected 0", got); n_fail++;
    end
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    n_chk++;
    if ({BUSY, DONE, ERR, LATCH_EN} !== 4'b0000) begin
      $display("FAIL reset_idle: got %b expected 0000", {BUSY, DONE, ERR, LATCH_EN}); n_fail++;
    end
  endtask

  task automatic test_basic;
    logic [4:0] got, exp;
    clear_rom();
    rom[8'h10] = mw(T_SEQ, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0) | fw;
    rom[8'h11] = mw(T_HALT, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    START = 1'b1;
    ENTRY = 8'h10;
    for (int c = 1; c <= 11; c++) begin
      @(negedge CLK);
      got = {LATCH_EN, REGBANK_WE, RAM_WE, DONE, BUSY};
      exp = {(c == 3 || c == 7), (c == 4), 1'b0, (c == 9), (c <= 8)};
      n_chk++;
      if (got !== exp) begin
        $display("FAIL basic_strobes cycle %0d: got %b expected %b", c, got, exp); n_fail++;
      end
      if (c == 1 || c == 5) begin
        n_chk++;
        if (UADDR !== ((c == 1) ? 8'h10 : 8'h11)) begin
          $display("FAIL basic_uaddr cycle %0d: got %h", c, UADDR); n_fail++;
        end
      end
      if (c == 3) begin
        n_chk++;
        if ({ALUC_IN, SEL_A_RB, SEL_B_RB, C_SEL_RB, Shifter_Sel, Y_X_Kmx_Sel} !==
            {4'hA, 6'd5, 6'd21, 6'd33, 2'd2, 1'b1}) begin
          $display("FAIL basic_fields: got %h %h %h %h %h %b expected a 05 15 21 2 1",
                   ALUC_IN, SEL_A_RB, SEL_B_RB, C_SEL_RB, Shifter_Sel, Y_X_Kmx_Sel);
          n_fail++;
        end
      end
      // A START while busy must not redirect the program.
      START = (c == 2);
      ENTRY = (c == 2) ? 8'h77 : 8'h10;
    end
  endtask

  task automatic test_branch;
    clear_rom();
    rom[8'h20] = mw(T_JC, 8'h40, 1'b0, 1'b0, 1'b0, 1'b1);
    rom[8'h21] = mw(T_HALT, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rom[8'h40] = mw(T_HALT, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rom[8'h22] = mw(T_JNC, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0);
    rom[8'h44] = mw(T_HALT, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    CY_OUT = 1'b1;
    kick(8'h20);
    repeat (4) @(negedge CLK);
    n_chk++;
    if (UADDR !== 8'h40) begin
      $display("FAIL jc_taken: got %h expected 40", UADDR); n_fail++;
    end
    repeat (5) @(negedge CLK);
    CY_OUT = 1'b0;
    kick(8'h20);
    repeat (4) @(negedge CLK);
    n_chk++;
    if (UADDR !== 8'h21) begin
      $display("FAIL jc_not_taken: got %h expected 21", UADDR); n_fail++;
    end
    repeat (5) @(negedge CLK);
    // Stored flag is now 0 and this word does not update it.
    CY_OUT = 1'b1;
    kick(8'h22);
    repeat (4) @(negedge CLK);
    n_chk++;
    if (UADDR !== 8'h44) begin
      $display("FAIL jnc_stored_flag: got %h expected 44", UADDR); n_fail++;
    end
    repeat (5) @(negedge CLK);
    CY_OUT = 1'b0;
  endtask

  task automatic test_wrap;
    clear_rom();
    rom[8'hFF] = mw(T_SEQ, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    rom[8'h00] = mw(T_HALT, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    kick(8'hFF);
    repeat (3) @(negedge CLK);
    n_chk++;
    if ({REGBANK_WE, RAM_WE} !== 2'b01) begin
      $display("FAIL ram_we: got %b expected 01", {REGBANK_WE, RAM_WE}); n_fail++;
    end
    @(negedge CLK);
    n_chk++;
    if (UADDR !== 8'h00) begin
      $display("FAIL seq_wrap: got %h expected 00", UADDR); n_fail++;
    end
    repeat (5) @(negedge CLK);
  endtask

  task automatic test_call_ret;
    clear_rom();
    rom[8'h05] = mw(T_CALL, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    rom[8'h80] = mw(T_RET, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rom[8'h06] = mw(T_HALT, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    kick(8'h05);
    for (int c = 1; c <= 13; c++) begin
      if (c == 1 || c == 5 || c == 9) begin
        n_chk++;
        if (UADDR !== ((c == 1) ? 8'h05 : (c == 5) ? 8'h80 : 8'h06)) begin
          $display("FAIL call_ret_uaddr cycle %0d: got %h", c, UADDR); n_fail++;
        end
      end
      if (c == 13) begin
        n_chk++;
        if ({DONE, ERR, BUSY} !== 3'b100) begin
          $display("FAIL call_ret_done: got %b expected 100", {DONE, ERR, BUSY}); n_fail++;
        end
      end
      if (c < 13) @(negedge CLK);
    end
  endtask

  task automatic test_stack_overflow;
    clear_rom();
    for (int k = 0; k < 5; k++) rom[8'h30 + k] = mw(T_CALL, 8'(8'h31 + k), 1'b0, 1'b0, 1'b0, 1'b0);
    rom[8'h10] = mw(T_SEQ, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rom[8'h11] = mw(T_HALT, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    kick(8'h30);
    repeat (16) @(negedge CLK);
    n_chk++;
    if (UADDR !== 8'h34) begin
      $display("FAIL nest_uaddr: got %h expected 34", UADDR); n_fail++;
    end
    repeat (4) @(negedge CLK);
    n_chk++;
    if ({DONE, ERR, BUSY} !== 3'b110) begin
      $display("FAIL overflow_fault: got %b expected 110", {DONE, ERR, BUSY}); n_fail++;
    end
    @(negedge CLK);
    n_chk++;
    if ({DONE, ERR, BUSY} !== 3'b010) begin
      $display("FAIL err_sticky: got %b expected 010", {DONE, ERR, BUSY}); n_fail++;
    end
    kick(8'h10);
    n_chk++;
    if ({ERR, BUSY} !== 2'b01) begin
      $display("FAIL err_clear_on_start: got %b expected 01", {ERR, BUSY}); n_fail++;
    end
    repeat (9) @(negedge CLK);
  endtask

  task automatic test_ret_empty;
    do_reset();
    clear_rom();
    rom[8'h50] = mw(T_RET, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    kick(8'h50);
    repeat (4) @(negedge CLK);
    n_chk++;
    if ({DONE, ERR, BUSY} !== 3'b110) begin
      $display("FAIL ret_empty_fault: got %b expected 110", {DONE, ERR, BUSY}); n_fail++;
    end
  endtask

  task automatic test_carry_in;
    do_reset();
    clear_rom();
    rom[8'h60] = mw(T_SEQ, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    rom[8'h61] = mw(T_SEQ, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    rom[8'h62] = mw(T_SEQ, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rom[8'h63] = mw(T_HALT, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    CY_OUT = 1'b1;
    kick(8'h60);
    for (int c = 1; c <= 17; c++) begin
      if (c == 3 || c == 7 || c == 11) begin
        n_chk++;
        if ({LATCH_EN, CY_IN} !== {1'b1, (c == 7)}) begin
          $display("FAIL carry_in cycle %0d: got %b expected %b", c, {LATCH_EN, CY_IN}, {1'b1, (c == 7)});
          n_fail++;
        end
      end
      if (c < 17) @(negedge CLK);
    end
    n_chk++;
    if (DONE !== 1'b1) begin
      $display("FAIL carry_prog_done: got %b expected 1", DONE); n_fail++;
    end
    CY_OUT = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [44:0] got;
    do_reset();
    clear_rom();
    rom[8'h10] = mw(T_SEQ, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0) | fw;
    kick(8'h10);
    repeat (2) @(negedge CLK);
    n_chk++;
    if (LATCH_EN !== 1'b1) begin
      $display("FAIL mid_latch: got %b expected 1", LATCH_EN); n_fail++;
    end
    #1 RST_N = 1'b0;
    #1;
    got = {UADDR, ALUC_IN, SEL_A_RB, SEL_B_RB, C_SEL_RB, Shifter_Sel, Y_X_Kmx_Sel,
           CY_IN, LATCH_EN, REGBANK_WE, RAM_WE, BUSY, DONE, ERR};
    n_chk++;
    if (got !== '0) begin
      $display("FAIL async_reset_outputs: got %h expected 0", got); n_fail++;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      n_chk++;
      if ({REGBANK_WE, RAM_WE, LATCH_EN} !== 3'b000) begin
        $display("FAIL no_strobe_after_reset %0d: got %b expected 000", c, {REGBANK_WE, RAM_WE, LATCH_EN});
        n_fail++;
      end
    end
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    n_chk++;
    if ({BUSY, REGBANK_WE} !== 2'b00) begin
      $display("FAIL idle_after_reset: got %b expected 00", {BUSY, REGBANK_WE}); n_fail++;
    end
  endtask

  initial begin
    fw = '0;
    fw[23:0] = {2'd2, 6'd33, 6'd21, 6'd5, 4'hA};
    fw[24] = 1'b1;
    test_reset();
    test_basic();
    test_branch();
    test_wrap();
    test_call_ret();
    test_stack_overflow();
    test_ret_empty();
    test_carry_in();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
